not_gate_bist: RTL and testbench
================================

Name: not_gate_bist

Overview:
- Built-in self-test driver/checker for a single-bit inverter cell. Drives the cell's input `a` and observes its output `c`.
- Applies a pseudo-random stimulus stream and checks every response against the expected inverted value.
- Sits beside the inverter inside the tile top; results come out on spare output pins.

Parameters:
- N_VECTORS, 16: number of test vectors per run; legal range 1..255.
- SETTLE_CYCLES, 1: wait cycles between driving `a` and sampling `c`; legal range 0..15.
- LFSR_SEED, 8'hA5: nonzero reload value for the stimulus LFSR.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle run request
- dut_a  output  1  stimulus driven to the inverter input
- dut_c  input  1  inverter output under observation
- busy  output  1  high while a run is in progress
- done  output  1  high once a run completes; held until the next start or reset
- pass  output  1  valid when done=1; 1 when no mismatches occurred
- err_count  output  8  mismatch count, saturates at 255
- vec_count  output  8  number of vectors sampled so far
- stuck  output  1  stuck-output flag (see Optional Feature)

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values (all outputs and internal state):
  - busy=0, done=0, pass=0, err_count=0, vec_count=0, dut_a=0, stuck=0.
  - LFSR loaded with LFSR_SEED; FSM in IDLE.
- LFSR:
  - 8-bit Fibonacci; shifts left by one bit.
  - New bit0 = q[7]^q[5]^q[4]^q[3].
  - dut_a = q[0] (registered).
  - Advances exactly once per vector, on leaving SAMPLE.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
  - IDLE: start=1 -> DRIVE; clear err_count, vec_count, done, pass; reload LFSR_SEED; busy=1.
  - DRIVE: dut_a holds q[0] for this vector. Next state is SETTLE if SETTLE_CYCLES>0, otherwise SAMPLE.
  - SETTLE: wait counter counts SETTLE_CYCLES cycles, then goes to SAMPLE.
  - SAMPLE: compare dut_c against ~dut_a.
    - On mismatch, err_count increments by 1, saturating at 255.
    - vec_count increments by 1.
    - LFSR advances.
    - If the new vec_count == N_VECTORS -> DONE; otherwise -> DRIVE.
  - DONE: busy=0, done=1, pass=(err_count==0) & ~stuck. start=1 restarts exactly as from IDLE.
- Timing: each vector takes 2+SETTLE_CYCLES cycles. A run from the start edge to done=1 takes N_VECTORS*(2+SETTLE_CYCLES) cycles, plus 1 cycle for the IDLE->DRIVE entry.
- start while busy=1 is ignored and has no effect on the counters.
- rst asserted mid-run: the run aborts immediately and all state returns to its reset values. No partial result is retained.
- rst and start asserted in the same cycle: rst wins.
- dut_c is sampled only in SAMPLE. Its value in any other state is don't-care.

Optional Feature:
- Macro: BIST_STUCK_DETECT_EN.
- Defined:
  - Two sticky bits record whether dut_c was sampled as 0 and as 1 during the run. Both clear on start.
  - On entering DONE, stuck=1 unless both values were seen.
  - stuck=1 forces pass=0 even when err_count==0.
- Undefined: stuck is tied to 0, and pass depends only on err_count.

Test Plan:
- Ideal inverter (dut_c=~dut_a combinationally), defaults, pulse start -> busy=1 next cycle; done=1 after 49 cycles; pass=1, err_count=0, vec_count=16.
- Buffer model (dut_c=dut_a), N_VECTORS=16 -> done=1, pass=0, err_count=16, vec_count=16.
- dut_c tied to 1, defaults -> err_count equals the number of vectors with q[0]=1; pass=0. With BIST_STUCK_DETECT_EN defined, stuck=1.
- Ideal inverter, N_VECTORS=255, mismatch forced on every vector -> err_count=255 with no wrap; done=1.
- rst asserted for 1 cycle at vector 5 -> busy=0, done=0, err_count=0, vec_count=0, dut_a=0. A following start completes a normal 49-cycle run with pass=1.
- start pulsed repeatedly while busy -> no restart and no counter disturbance; vec_count progresses 1..16 monotonically; done at the same cycle as the single-start case.

Source files
------------

// File: rtl/not_gate_bist.sv
// Built-in self-test driver/checker for a single-bit inverter cell: LFSR stimulus on dut_a, response check on dut_c.
// Optional stuck-output detection is enabled by defining BIST_STUCK_DETECT_EN.
module not_gate_bist #(
    parameter int unsigned N_VECTORS     = 16,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] vec_count,
    output logic       stuck
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] wait_q;
    logic [7:0] err_q, err_d;
    logic [7:0] vec_q, vec_d;
    logic       dut_a_q, busy_q, done_q, pass_q, stuck_q;
    logic       mismatch, stuck_d, launch;

    // A run may be (re)launched only from IDLE or DONE; start while busy is ignored.
    assign launch = start && (state_q == S_IDLE || state_q == S_DONE);

`ifdef BIST_STUCK_DETECT_EN
    logic seen0_q, seen1_q;

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            seen0_q <= 1'b0;
            seen1_q <= 1'b0;
        end else if (state_q == S_SAMPLE) begin
            seen0_q <= seen0_q | ~dut_c;
            seen1_q <= seen1_q | dut_c;
        end
    end
`endif

    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        mismatch = (dut_c == dut_a_q);
        err_d    = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        vec_d    = vec_q + 8'd1;
`ifdef BIST_STUCK_DETECT_EN
        // Include the sample taken on the final edge, which the sticky bits have not yet absorbed.
        stuck_d  = ~((seen0_q | ~dut_c) & (seen1_q | dut_c));
`else
        stuck_d  = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            wait_q  <= 4'd0;
            err_q   <= 8'd0;
            vec_q   <= 8'd0;
            dut_a_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state_q <= S_DRIVE;
                        lfsr_q  <= LFSR_SEED;
                        dut_a_q <= LFSR_SEED[0];
                        wait_q  <= 4'd0;
                        err_q   <= 8'd0;
                        vec_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        stuck_q <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    wait_q  <= 4'd0;
                    state_q <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
                end
                S_SETTLE: begin
                    if (wait_q == 4'(SETTLE_CYCLES - 1)) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    err_q   <= err_d;
                    vec_q   <= vec_d;
                    lfsr_q  <= lfsr_d;
                    dut_a_q <= lfsr_d[0];
                    if (vec_d == 8'(N_VECTORS)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 8'd0) && !stuck_d;
                        stuck_q <= stuck_d;
                    end else begin
                        state_q <= S_DRIVE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dut_a     = dut_a_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_count = vec_q;
    assign stuck     = stuck_q;

endmodule

// File: tb/tb_not_gate_bist.sv
// Self-checking bench for not_gate_bist: table of cell behaviours plus hand-written reset/start corner sequences.
module tb_not_gate_bist;

    localparam int M_IDEAL  = 0;
    localparam int M_BUFFER = 1;
    localparam int M_TIED1  = 2;
    localparam int M_TIED0  = 3;

`ifdef BIST_STUCK_DETECT_EN
    localparam logic STUCK_EN = 1'b1;
`else
    localparam logic STUCK_EN = 1'b0;
`endif

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        logic  exp_pass;
        logic  exp_stuck;
    } vec_t;

    logic       clk, rst, start, start_l;
    logic       dut_a, dut_c, busy, done, pass, stuck;
    logic [7:0] err_count, vec_count;
    logic       dut_a_l, dut_c_l, busy_l, done_l, pass_l, stuck_l;
    logic [7:0] err_l, vec_l;
    int         mode;
    int         n_pass, n_total;

    not_gate_bist u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_a(dut_a), .dut_c(dut_c),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .vec_count(vec_count), .stuck(stuck)
    );

    not_gate_bist #(.N_VECTORS(255), .SETTLE_CYCLES(0)) u_long (
        .clk(clk), .rst(rst), .start(start_l), .dut_a(dut_a_l), .dut_c(dut_c_l),
        .busy(busy_l), .done(done_l), .pass(pass_l), .err_count(err_l),
        .vec_count(vec_l), .stuck(stuck_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            M_IDEAL:  dut_c = ~dut_a;
            M_BUFFER: dut_c = dut_a;
            M_TIED1:  dut_c = 1'b1;
            default:  dut_c = 1'b0;
        endcase
    end
    assign dut_c_l = dut_a_l;   // buffer: every vector mismatches

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then count edges (start edge = 1) until done, bounded.
    task automatic run(input bit spam, output int cycles, output bit mono_ok);
        int prev;
        start = 1'b1;
        tick();
        start   = 1'b0;
        cycles  = 1;
        prev    = 0;
        mono_ok = 1'b1;
        check("busy_after_start", busy, 1);
        while (!done && cycles < 300) begin
            if (spam) start = ~start;
            tick();
            cycles++;
            if (!(vec_count == prev || vec_count == prev + 1)) mono_ok = 1'b0;
            prev = vec_count;
        end
        start = 1'b0;
        check("run_terminates", int'(cycles < 300), 1);
    endtask

    initial begin
        vec_t tbl[4];
        int   cyc;
        bit   mono;

        n_pass  = 0;
        n_total = 0;
        mode    = M_IDEAL;
        rst     = 1'b1;
        start   = 1'b0;
        start_l = 1'b0;
        // Hand-derived LFSR q[0] sequence from 8'hA5: 1010011101110110 -> ten 1s, six 0s.
        tbl[0] = '{"ideal",  M_IDEAL,  0,  1'b1, 1'b0};
        tbl[1] = '{"buffer", M_BUFFER, 16, 1'b0, 1'b0};
        tbl[2] = '{"tied1",  M_TIED1,  10, 1'b0, STUCK_EN};
        tbl[3] = '{"tied0",  M_TIED0,  6,  1'b0, STUCK_EN};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_vec", vec_count, 0);
        check("rst_dut_a", dut_a, 0);
        check("rst_stuck", stuck, 0);

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run(1'b0, cyc, mono);
            check({tbl[i].name, "_cycles"}, cyc, 49);
            check({tbl[i].name, "_done"}, done, 1);
            check({tbl[i].name, "_busy"}, busy, 0);
            check({tbl[i].name, "_pass"}, pass, tbl[i].exp_pass);
            check({tbl[i].name, "_err"}, err_count, tbl[i].exp_err);
            check({tbl[i].name, "_vec"}, vec_count, 16);
            check({tbl[i].name, "_stuck"}, stuck, tbl[i].exp_stuck);
            tick();
            check({tbl[i].name, "_done_held"}, done, 1);
        end

        // Reset mid-run at vector 5 with errors accumulating.
        mode  = M_BUFFER;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (vec_count != 8'd5 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("midrst_reached_v5", int'(cyc < 100), 1);
        check("midrst_err_before", err_count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err_count, 0);
        check("midrst_vec", vec_count, 0);
        check("midrst_dut_a", dut_a, 0);
        tick();
        check("midrst_stays_idle", busy, 0);
        mode = M_IDEAL;
        run(1'b0, cyc, mono);
        check("after_rst_cycles", cyc, 49);
        check("after_rst_pass", pass, 1);
        check("after_rst_vec", vec_count, 16);

        // start toggled throughout the run must not restart or disturb counters.
        run(1'b1, cyc, mono);
        check("spam_cycles", cyc, 49);
        check("spam_monotonic", mono, 1);
        check("spam_vec", vec_count, 16);
        check("spam_err", err_count, 0);
        check("spam_pass", pass, 1);

        // rst and start in the same cycle: rst wins.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_done", done, 0);
        tick();
        check("rst_start_idle", busy, 0);

        // 255 vectors, zero settle, every vector mismatching: err_count reaches 255 without wrapping.
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        cyc     = 1;
        check("long_busy", busy_l, 1);
        while (!done_l && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("long_cycles", cyc, 511);
        check("long_err", err_l, 255);
        check("long_vec", vec_l, 255);
        check("long_pass", pass_l, 0);
        check("long_done", done_l, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
